// File: rtl/capture_dma_ctrl.sv
// capture_dma_ctrl
// Copies one captured packet from the on-chip packet buffer into an SDRAM
// window, one 32-bit word per Avalon-MM write toward the F2SDRAM port.
//
// Ports
//   clk             system clock
//   reset           synchronous, active-low reset
//   ctrl            control register: bit 2 = START, bit 3 = ABORT
//   pkt_begin       first buffer word index (inclusive)
//   pkt_end         last buffer word index (inclusive)
//   write_address   SDRAM byte base address (bits 1:0 ignored)
//   state           FSM state: IDLE=00 FETCH=01 WRITE=10 DONE=11
//   busy / done     run in progress / run finished
//   error           last run rejected or aborted (valid while done=1)
//   xfer_count      words accepted by SDRAM in the current or last run
//   buf_rd_en/addr  packet buffer read strobe and word address
//   buf_rd_data     buffer data, valid the cycle after buf_rd_en
//   avm_*           Avalon-MM write master toward SDRAM
module capture_dma_ctrl #(
    parameter int N      = 32,
    parameter int BUF_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      ctrl,
    input  logic [N-1:0]      pkt_begin,
    input  logic [N-1:0]      pkt_end,
    input  logic [N-1:0]      write_address,
    output logic [1:0]        state,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [N-1:0]      xfer_count,
    output logic              buf_rd_en,
    output logic [BUF_AW-1:0] buf_rd_addr,
    input  logic [N-1:0]      buf_rd_data,
    output logic [N-1:0]      avm_address,
    output logic              avm_write,
    output logic [N-1:0]      avm_writedata,
    input  logic              avm_waitrequest
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Largest run the buffer can hold: 2^BUF_AW words, at N+1 bits.
    localparam logic [N:0]   MAX_LEN = {{(N-BUF_AW){1'b0}}, 1'b1, {BUF_AW{1'b0}}};
    localparam logic [N-1:0] ONE_N   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N:0]   ONE_N1  = {{N{1'b0}}, 1'b1};

    state_t      state_r;
    logic        start_q_r;
    logic        armed_r;      // START has been seen low since reset
    logic        phase_b_r;    // FETCH sub-phase: 0 = read issued, 1 = data capture
    logic        abort_r;      // ABORT seen while a write was pending
    logic [N-1:0] begin_r;
    logic [N-1:0] base_r;
    logic [N:0]   len_r;

    logic        start_edge_s;
    logic [N:0]  len_s;
    logic [N-1:0] next_count_s;
    logic [N-1:0] rd_sum_s;
    logic [N-1:0] wr_addr_s;
    logic        last_word_s;
    logic        unused_bits_s;

    // armed_r keeps a START level held high across reset from looking like a new edge.
    assign start_edge_s = ctrl[2] & ~start_q_r & armed_r;
    assign len_s        = {1'b0, pkt_end} - {1'b0, pkt_begin} + ONE_N1;
    // xfer_count doubles as the word index of the run.
    assign next_count_s = xfer_count + ONE_N;
    assign rd_sum_s     = begin_r + next_count_s;
    assign wr_addr_s    = base_r + (xfer_count << 2);
    assign last_word_s  = ({1'b0, next_count_s} == len_r);
    assign state        = state_r;

    assign unused_bits_s = ^{ctrl[N-1:4], ctrl[1:0], write_address[1:0], rd_sum_s[N-1:BUF_AW]};

    // Run sequencer: state, run context and every registered output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            start_q_r     <= 1'b0;
            armed_r       <= 1'b0;
            phase_b_r     <= 1'b0;
            abort_r       <= 1'b0;
            begin_r       <= {N{1'b0}};
            base_r        <= {N{1'b0}};
            len_r         <= {(N+1){1'b0}};
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            xfer_count    <= {N{1'b0}};
            buf_rd_en     <= 1'b0;
            buf_rd_addr   <= {BUF_AW{1'b0}};
            avm_address   <= {N{1'b0}};
            avm_write     <= 1'b0;
            avm_writedata <= {N{1'b0}};
        end else begin
            start_q_r <= ctrl[2];
            if (!ctrl[2]) begin
                armed_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_edge_s) begin
                        begin_r    <= pkt_begin;
                        base_r     <= {write_address[N-1:2], 2'b00};
                        len_r      <= len_s;
                        xfer_count <= {N{1'b0}};
                        error      <= 1'b0;
                        abort_r    <= 1'b0;
                        if (pkt_end < pkt_begin) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else if (len_s > MAX_LEN) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                            error   <= 1'b1;
                        end else begin
                            state_r     <= ST_FETCH;
                            busy        <= 1'b1;
                            phase_b_r   <= 1'b0;
                            buf_rd_en   <= 1'b1;
                            buf_rd_addr <= pkt_begin[BUF_AW-1:0];
                        end
                    end
                end
                ST_FETCH: begin
                    if (ctrl[3]) begin
                        // Any read still in flight is simply dropped.
                        state_r   <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        error     <= 1'b1;
                        buf_rd_en <= 1'b0;
                    end else if (!phase_b_r) begin
                        buf_rd_en <= 1'b0;
                        phase_b_r <= 1'b1;
                    end else begin
                        avm_writedata <= buf_rd_data;
                        avm_address   <= wr_addr_s;
                        avm_write     <= 1'b1;
                        state_r       <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // A pending write is never withdrawn; ABORT takes effect on acceptance.
                    if (ctrl[3]) begin
                        abort_r <= 1'b1;
                    end
                    if (!avm_waitrequest) begin
                        xfer_count <= next_count_s;
                        avm_write  <= 1'b0;
                        if (ctrl[3] || abort_r || last_word_s) begin
                            state_r <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            error   <= ctrl[3] | abort_r;
                        end else begin
                            state_r     <= ST_FETCH;
                            phase_b_r   <= 1'b0;
                            buf_rd_en   <= 1'b1;
                            buf_rd_addr <= rd_sum_s[BUF_AW-1:0];
                        end
                    end
                end
                ST_DONE: begin
                    if (!ctrl[2]) begin
                        state_r <= ST_IDLE;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    buf_rd_en <= 1'b0;
                    avm_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_dma_ctrl.sv
// Scoreboard bench for capture_dma_ctrl: stimulus pushes expected buffer reads
// and SDRAM writes into queues; a negedge monitor drives waitrequest stalls and
// pops/compares whenever the DUT presents a read strobe or an accepted write.
module tb_capture_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ctrl = 32'h0;
    logic [31:0] pkt_begin = 32'h0;
    logic [31:0] pkt_end = 32'h0;
    logic [31:0] write_address = 32'h0;
    logic [1:0]  state;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] xfer_count;
    logic        buf_rd_en;
    logic [9:0]  buf_rd_addr;
    logic [31:0] buf_rd_data = 32'h0;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [9:0]  rd_q[$];
    int          acc_total = 0;
    int          stall_at = -1;
    int          stall_left = 0;
    logic [31:0] mem [0:1023];

    capture_dma_ctrl #(.N(32), .BUF_AW(10)) dut (
        .clk(clk), .reset(reset), .ctrl(ctrl),
        .pkt_begin(pkt_begin), .pkt_end(pkt_end), .write_address(write_address),
        .state(state), .busy(busy), .done(done), .error(error),
        .xfer_count(xfer_count), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
        .buf_rd_data(buf_rd_data), .avm_address(avm_address), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA0 + i;
    end

    // Buffer model: one-cycle read latency.
    always @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: decide stall for this cycle, then score reads and writes.
    always @(negedge clk) begin : mon
        logic stall;
        stall = avm_write && (acc_total == stall_at) && (stall_left > 0);
        if (stall) stall_left--;
        avm_waitrequest = stall;
        if (buf_rd_en) begin
            if (rd_q.size() == 0) check("read_queue_nonempty", rd_q.size(), 1);
            else check("rd_addr", buf_rd_addr, rd_q.pop_front());
        end
        if (avm_write) begin
            if (wr_q.size() == 0) check("write_queue_nonempty", wr_q.size(), 1);
            else if (stall) check("hold_stable", {avm_address, avm_writedata}, wr_q[0]);
            else begin
                check("write", {avm_address, avm_writedata}, wr_q.pop_front());
                acc_total++;
            end
        end
    end

    task automatic push_word(input logic [9:0] ra, input logic [31:0] wa, input logic [31:0] wd);
        rd_q.push_back(ra);
        wr_q.push_back({wa, wd});
    endtask

    task automatic run(input logic [31:0] b, input logic [31:0] e, input logic [31:0] base,
                       input int exp_cyc, input logic [31:0] exp_xfer, input logic exp_err,
                       input bit scramble);
        int k;
        @(negedge clk);
        pkt_begin = b; pkt_end = e; write_address = base; ctrl = 32'h4;
        @(negedge clk);
        k = 1;
        if (scramble) begin
            pkt_begin = 32'h0; pkt_end = 32'h3FF; write_address = 32'hDEAD_BEEC;
        end
        while (!done && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done, 1);
        check("run_cycles", k, exp_cyc);
        check("busy_in_done", busy, 0);
        check("state_done", state, 2'b11);
        check("error", error, exp_err);
        check("xfer_count", xfer_count, exp_xfer);
        ctrl = 32'h0;
        @(negedge clk);
        check("state_idle", state, 2'b00);
        check("done_clear", done, 0);
        check("queues_drained", wr_q.size() + rd_q.size(), 0);
    endtask

    task automatic wait_stall(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!(avm_write && avm_waitrequest) && k < 200);
        check(name, avm_write && avm_waitrequest, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs_a", {state, busy, done, error, xfer_count, buf_rd_en, buf_rd_addr}, 0);
        check("reset_outputs_b", {avm_address, avm_write, avm_writedata}, 0);
        reset = 1'b1;
        @(negedge clk);

        // 4-word run, no stalls; pkt registers scrambled after start must not matter.
        for (int i = 0; i < 4; i++) push_word(10'(4 + i), 32'h2000_0000 + 4 * i, 32'hA4 + i);
        run(32'd4, 32'd7, 32'h2000_0000, 13, 32'd4, 1'b0, 1'b1);

        // Same run with 5 stall cycles on word 2.
        for (int i = 0; i < 4; i++) push_word(10'(4 + i), 32'h2000_0000 + 4 * i, 32'hA4 + i);
        stall_at = acc_total + 2;
        stall_left = 5;
        run(32'd4, 32'd7, 32'h2000_0000, 18, 32'd4, 1'b0, 1'b0);

        // Buffer address wrap; base low bits dropped.
        push_word(10'd1022, 32'h1000_0000, 32'h49E);
        push_word(10'd1023, 32'h1000_0004, 32'h49F);
        push_word(10'd0,    32'h1000_0008, 32'hA0);
        push_word(10'd1,    32'h1000_000C, 32'hA1);
        run(32'd1022, 32'd1025, 32'h1000_0003, 13, 32'd4, 1'b0, 1'b0);

        // Zero-length run, then an over-long run.
        run(32'd5, 32'd3, 32'h4000_0000, 1, 32'd0, 1'b0, 1'b0);
        run(32'd0, 32'd1024, 32'h4000_0000, 1, 32'd0, 1'b1, 1'b0);

        // Largest legal run: whole buffer.
        for (int i = 0; i < 1024; i++) push_word(10'(i), 32'h8000_0000 + 4 * i, 32'hA0 + i);
        run(32'd0, 32'd1023, 32'h8000_0000, 3073, 32'd1024, 1'b0, 1'b0);

        // ABORT while word 3 of an 8-word run is stalled.
        for (int i = 0; i < 4; i++) push_word(10'(16 + i), 32'h5000_0000 + 4 * i, 32'hB0 + i);
        stall_at = acc_total + 3;
        stall_left = 6;
        @(negedge clk);
        pkt_begin = 32'd16; pkt_end = 32'd23; write_address = 32'h5000_0000; ctrl = 32'h4;
        wait_stall("abort_stall_seen");
        ctrl = 32'hC;
        begin
            int k;
            k = 0;
            while (!done && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        check("abort_done", done, 1);
        check("abort_error", error, 1);
        check("abort_xfer", xfer_count, 32'd4);
        check("abort_state", state, 2'b11);
        ctrl = 32'h0;
        @(negedge clk);
        check("abort_idle", state, 2'b00);
        check("abort_drained", wr_q.size() + rd_q.size(), 0);

        // Reset in the middle of a stalled write, START held high through it.
        push_word(10'd0, 32'h3000_0000, 32'hA0);
        stall_at = acc_total;
        stall_left = 1000;
        @(negedge clk);
        pkt_begin = 32'd0; pkt_end = 32'd7; write_address = 32'h3000_0000; ctrl = 32'h4;
        wait_stall("reset_stall_seen");
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("reset_drops_write", avm_write, 0);
        check("reset_state", state, 2'b00);
        check("reset_busy", busy, 0);
        stall_left = 0;
        wr_q.delete();
        rd_q.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("no_restart_state", state, 2'b00);
        check("no_restart_busy", busy, 0);
        ctrl = 32'h0;
        @(negedge clk);
        push_word(10'd2, 32'h3000_0100, 32'hA2);
        push_word(10'd3, 32'h3000_0104, 32'hA3);
        run(32'd2, 32'd3, 32'h3000_0100, 7, 32'd2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
